// File: rtl/dram_refresh_arbiter.sv
// FastRAM FPM DRAM sequencer: arbitrates 68000 bus accesses against interval-timed
// CAS-before-RAS refresh, hiding refresh in idle time and forcing it once debt saturates.
module dram_refresh_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 109,
  parameter int unsigned MAX_DEBT         = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ACC_REQ,
  input  logic       ACC_UBE,
  input  logic       ACC_LBE,
  output logic       RASn,
  output logic       UCASn,
  output logic       LCASn,
  output logic       MUX_COL,
  output logic       ACC_ACK,
  output logic       REF_BUSY,
  output logic [2:0] DEBT,
  output logic       OVERRUN
);

  localparam int unsigned CntW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0] DebtMax = 3'(MAX_DEBT);

  typedef enum logic [2:0] {
    StIdle,
    StAccRow,
    StAccCol,
    StAccCas,
    StRefCas,
    StRefRas,
    StPre
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] interval_q;
  logic            ras_cnt_q;
  logic            tick;
  logic            debt_full;
  logic            ref_start;

  assign tick      = (interval_q == CntLast);
  assign debt_full = (DEBT >= DebtMax);
  // Forced refresh outranks a pending access; hidden refresh only when the bus is quiet.
  assign ref_start = (state_q == StIdle) && (debt_full || (!ACC_REQ && (DEBT != 3'd0)));

  // Interval timer, refresh debt and sticky overrun flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      interval_q <= '0;
      DEBT       <= 3'd0;
      OVERRUN    <= 1'b0;
    end else begin
      interval_q <= tick ? '0 : interval_q + 1'b1;
      case ({tick, ref_start})
        2'b10: begin
          if (debt_full) begin
            OVERRUN <= 1'b1;
          end else begin
            DEBT <= DEBT + 3'd1;
          end
        end
        2'b01:   DEBT <= DEBT - 3'd1;
        // A tick landing on a refresh start is paid off immediately.
        default: DEBT <= DEBT;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (ref_start) begin
          state_d = StRefCas;
        end else if (ACC_REQ) begin
          state_d = StAccRow;
        end
      end
      StAccRow: state_d = StAccCol;
      StAccCol: state_d = StAccCas;
      StAccCas: begin
        if (!ACC_REQ) begin
          state_d = StPre;
        end
      end
      StRefCas: state_d = StRefRas;
      StRefRas: begin
        if (ras_cnt_q) begin
          state_d = StPre;
        end
      end
      StPre:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State plus strobes, all registered from the next state so nothing reaches a pin
  // combinationally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      ras_cnt_q <= 1'b0;
      RASn      <= 1'b1;
      UCASn     <= 1'b1;
      LCASn     <= 1'b1;
      MUX_COL   <= 1'b0;
      ACC_ACK   <= 1'b0;
      REF_BUSY  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ras_cnt_q <= (state_q == StRefRas) ? ~ras_cnt_q : 1'b0;
      RASn      <= !(state_d inside {StAccRow, StAccCol, StAccCas, StRefRas});
      UCASn     <= !(((state_d == StAccCas) && ACC_UBE) || (state_d inside {StRefCas, StRefRas}));
      LCASn     <= !(((state_d == StAccCas) && ACC_LBE) || (state_d inside {StRefCas, StRefRas}));
      MUX_COL   <= (state_d inside {StAccCol, StAccCas});
      ACC_ACK   <= (state_d == StAccCas);
      // Precharge after a refresh still counts as refresh time.
      REF_BUSY  <= (state_d inside {StRefCas, StRefRas}) ||
                   ((state_d == StPre) && (state_q == StRefRas));
    end
  end

endmodule

// File: doc/dram_refresh_arbiter.md
Name: dram_refresh_arbiter

Overview:
- Sequences the FastRAM FPM DRAM array between 68000 bus accesses and CAS-before-RAS refresh.
- Replaces free-running refresh with an interval-timed scheduler: refresh debt accumulates, is hidden in idle bus time, and is forced once debt saturates.
- Sits between the bus decoder (which raises ACC_REQ for a matched RAM cycle) and the DRAM strobes and row/column address mux.

Parameters:
- REFRESH_INTERVAL, 109: CLK cycles per refresh tick (≈15.4 µs at 7.09 MHz).
- MAX_DEBT, 4: owed-refresh count at which refresh preempts access; 1..7.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ACC_REQ  input  1  access request from decoder; level, held until the bus cycle ends.
- ACC_UBE  input  1  upper byte enable (from !UDSn), sampled while in ACC_CAS.
- ACC_LBE  input  1  lower byte enable (from !LDSn), sampled while in ACC_CAS.
- RASn  output  1  DRAM row strobe, active low.
- UCASn  output  1  upper column strobe, active low.
- LCASn  output  1  lower column strobe, active low.
- MUX_COL  output  1  0 = row address on MADDR, 1 = column address.
- ACC_ACK  output  1  high while column strobes are issued for the access.
- REF_BUSY  output  1  high during any refresh state.
- DEBT  output  3  refresh operations currently owed.
- OVERRUN  output  1  sticky; set when a tick arrives with DEBT already at MAX_DEBT.

Behaviour:
- Reset, asynchronous: state IDLE, interval counter 0, DEBT 0, OVERRUN 0. Outputs: RASn/UCASn/LCASn=1, MUX_COL=0, ACC_ACK=0, REF_BUSY=0. Release is synchronous to the next rising CLK edge.
- All outputs are registered; no combinational path from inputs to strobes.
- Interval counter:
  - Counts 0..REFRESH_INTERVAL-1 and wraps; the wrap cycle is a tick.
  - Tick: DEBT+1, saturating at MAX_DEBT. If DEBT==MAX_DEBT at the tick, DEBT holds and OVERRUN sets.
- Refresh start (entry to REF_CAS): DEBT-1.
- Tick and refresh start in the same cycle: DEBT unchanged.
- OVERRUN clears only on RESET.
- States:
  - IDLE: all strobes high, MUX_COL=0. Priority:
    1. DEBT==MAX_DEBT -> REF_CAS (forced, even if ACC_REQ).
    2. ACC_REQ -> ACC_ROW.
    3. DEBT>0 -> REF_CAS (hidden).
    4. Otherwise stay.
  - ACC_ROW: RASn=0, MUX_COL=0, one cycle -> ACC_COL.
  - ACC_COL: RASn=0, MUX_COL=1, one cycle -> ACC_CAS.
  - ACC_CAS: RASn=0, MUX_COL=1, UCASn=!ACC_UBE, LCASn=!ACC_LBE (registered), ACC_ACK=1.
    - Stay while ACC_REQ=1.
    - ACC_REQ=0 -> PRE.
    - A byte lane whose enable is 0 keeps its CAS high for the whole state.
  - REF_CAS: UCASn=LCASn=0, RASn=1, REF_BUSY=1, one cycle -> REF_RAS.
  - REF_RAS: UCASn=LCASn=0, RASn=0, REF_BUSY=1, two cycles (internal 1-bit count) -> PRE.
  - PRE: all strobes high, MUX_COL=0, one cycle precharge -> IDLE. REF_BUSY=1 if entered from REF_RAS, else 0.
- Minimum access latency: ACC_REQ rises -> ACC_ACK rises 3 cycles later (IDLE sample, ACC_ROW, ACC_COL).
- ACC_REQ is never dropped mid-refresh. A request arriving during REF_* or PRE waits; it is served from IDLE after PRE.
- ACC_REQ dropping in ACC_ROW/ACC_COL (aborted cycle): the sequence still completes ACC_ROW -> ACC_COL -> ACC_CAS. In ACC_CAS, ACC_REQ=0 goes directly to PRE.
- Back-to-back accesses: PRE is always inserted between RAS low periods.
- Refresh never starts while RASn=0 for an access. Forced refresh waits for the current access to reach IDLE.
- Interval counter keeps running in every state, including during accesses and refreshes.

Test Plan:
- Reset mid-access: ACC_REQ held, assert RESET in ACC_CAS -> strobes high and DEBT=0 in the same cycle, asynchronously. After release, the first tick arrives at cycle REFRESH_INTERVAL.
- Idle hidden refresh: ACC_REQ=0 for 3×109 cycles -> exactly 3 refreshes. Each is REF_CAS(1), REF_RAS(2), PRE(1), starting 1 cycle after a tick. DEBT returns to 0 each time.
- Single access: ACC_REQ=1, UBE=1, LBE=0 from IDLE with DEBT=0 -> RASn low at +1, MUX_COL=1 at +2, UCASn low and ACC_ACK=1 at +3, LCASn stays 1. Drop ACC_REQ -> PRE, then IDLE.
- Starvation/forced refresh: ACC_REQ toggled back-to-back (always re-requested in IDLE) for 5×109 cycles with MAX_DEBT=4 -> DEBT reaches 4, the next IDLE goes to REF_CAS despite ACC_REQ=1, DEBT drops to 3, OVERRUN stays 0.
- Overrun: single access held in ACC_CAS for 6×109 cycles -> DEBT saturates at 4, OVERRUN=1 at the 5th tick. After release, 4 consecutive refreshes drain DEBT to 0 while ACC_REQ=0.
- Simultaneous tick and refresh start: DEBT=1, tick on the cycle of entry to REF_CAS -> DEBT stays 1, then one more refresh brings it to 0.
